// File: rtl/prbs_checker_pkg.sv
// Shared definitions for the PRBS checker: lock FSM encoding, PRBS31 defaults,
// and the saturating-add helper used by both error counters.
package prbs_checker_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  localparam int          PRBS31_WIDTH = 31;
  localparam logic [30:0] PRBS31_POLY  = 31'h10000001;

  // Clamps at max instead of wrapping; a must already be <= max.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] max);
    return (b >= max - a) ? max : a + b;
  endfunction

endpackage

// File: rtl/prbs_checker_lfsr.sv
// Combinational Fibonacci LFSR step over DATA_WIDTH bits, MSB first. With
// LFSR_FEED_FORWARD=1 the received bits are shifted in, so data_out is the error pattern.
module prbs_checker_lfsr #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter int                    DATA_WIDTH        = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  logic [LFSR_WIDTH-1:0] st_v;
  logic [DATA_WIDTH-1:0] dout_v;
  logic                  fb_v;

  always_comb begin
    st_v   = state_in;
    dout_v = '0;
    fb_v   = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb_v = st_v[LFSR_WIDTH-1] ^ data_in[i];
      for (int j = 1; j < LFSR_WIDTH; j++) begin
        if (LFSR_POLY[j]) fb_v = fb_v ^ st_v[j-1];
      end
      dout_v    = dout_v << 1;
      dout_v[0] = fb_v;
      st_v      = st_v << 1;
      st_v[0]   = LFSR_FEED_FORWARD ? data_in[i] : fb_v;
    end
    data_out  = dout_v;
    state_out = st_v;
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker with lock FSM and saturating error counters.
// Optional macro PRBS_CHECK_BIT_COUNT_EN builds the errored-bit counter.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int                    LFSR_WIDTH   = PRBS31_WIDTH,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = LFSR_WIDTH'(PRBS31_POLY),
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    LOCK_COUNT   = 4,
  parameter int                    UNLOCK_COUNT = 4,
  parameter int                    COUNT_WIDTH  = 32  // up to 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_in_valid,
  input  logic                   clear_count,
  output logic                   locked,
  output logic                   word_err,
  output logic [COUNT_WIDTH-1:0] word_err_count,
  output logic [COUNT_WIDTH-1:0] bit_err_count
);

  localparam int          RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int          RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [63:0] CNT_MAX = {64{1'b1}} >> (64 - COUNT_WIDTH);

  logic [LFSR_WIDTH-1:0]  state_q, state_d, lfsr_state_nxt;
  logic [DATA_WIDTH-1:0]  err_bits;
  lock_state_e            fsm_q, fsm_d;
  logic [RUN_W-1:0]       run_q, run_d, run_inc;
  logic                   locked_q, locked_d;
  logic                   word_err_q, word_err_d;
  logic [COUNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic                   word_bad;
  logic                   cnt_inc;

  prbs_checker_lfsr #(
    .LFSR_WIDTH       (LFSR_WIDTH),
    .LFSR_POLY        (LFSR_POLY),
    .LFSR_FEED_FORWARD(1'b1),
    .DATA_WIDTH       (DATA_WIDTH)
  ) u_lfsr (
    .data_in  (data_in),
    .state_in (state_q),
    .data_out (err_bits),
    .state_out(lfsr_state_nxt)
  );

  // An all-zero state predicts an all-zero stream, so it must never count as clean.
  assign word_bad = (state_q == '0) || (err_bits != '0);
  assign run_inc  = run_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    fsm_d      = fsm_q;
    run_d      = run_q;
    word_err_d = 1'b0;
    cnt_inc    = 1'b0;
    if (data_in_valid) begin
      state_d = lfsr_state_nxt;
      case (fsm_q)
        ST_UNLOCKED: begin
          fsm_d = ST_SYNC;
          run_d = '0;
        end
        ST_SYNC: begin
          word_err_d = word_bad;
          if (word_bad) begin
            run_d = '0;
          end else if (run_inc == RUN_W'(LOCK_COUNT)) begin
            fsm_d = ST_LOCKED;
            run_d = '0;
          end else begin
            run_d = run_inc;
          end
        end
        ST_LOCKED: begin
          word_err_d = word_bad;
          cnt_inc    = word_bad;
          if (!word_bad) begin
            run_d = '0;
          end else if (run_inc == RUN_W'(UNLOCK_COUNT)) begin
            fsm_d = ST_UNLOCKED;
            run_d = '0;
          end else begin
            run_d = run_inc;
          end
        end
        default: begin
          fsm_d = ST_UNLOCKED;
          run_d = '0;
        end
      endcase
    end
    locked_d = (fsm_d == ST_LOCKED);
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (clear_count) begin
      word_cnt_d = '0;
    end else if (cnt_inc) begin
      word_cnt_d = COUNT_WIDTH'(sat_add(64'(word_cnt_q), 64'd1, CNT_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= '0;
      fsm_q      <= ST_UNLOCKED;
      run_q      <= '0;
      locked_q   <= 1'b0;
      word_err_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fsm_q      <= fsm_d;
      run_q      <= run_d;
      locked_q   <= locked_d;
      word_err_q <= word_err_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign locked         = locked_q;
  assign word_err       = word_err_q;
  assign word_err_count = word_cnt_q;

`ifdef PRBS_CHECK_BIT_COUNT_EN
  localparam int POP_W = $clog2(DATA_WIDTH + 1);

  logic [POP_W-1:0]       pop_cnt;
  logic [COUNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) pop_cnt = pop_cnt + POP_W'(err_bits[i]);
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (clear_count) begin
      bit_cnt_d = '0;
    end else if (cnt_inc) begin
      bit_cnt_d = COUNT_WIDTH'(sat_add(64'(bit_cnt_q), 64'(pop_cnt), CNT_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) bit_cnt_q <= '0;
    else     bit_cnt_q <= bit_cnt_d;
  end

  assign bit_err_count = bit_cnt_q;
`else
  assign bit_err_count = '0;
`endif

endmodule
